// File: rtl/seven_segment_scheduler.sv
// Round-robin scheduler sharing one two-digit seven-segment display among several requesters.
// Also holds the seven_segment decoder it instantiates, so the block stays in one file.

module seven_segment (
  input  logic [4:0] number,
  output logic [6:0] tens_digit,
  output logic [6:0] ones_digit
);

  // Active-high segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [3:0] tens_val;
  logic [3:0] ones_val;

  assign tens_val   = 4'(number / 5'd10);
  assign ones_val   = 4'(number % 5'd10);
  assign tens_digit = pattern(tens_val);
  assign ones_digit = pattern(ones_val);

endmodule

module seven_segment_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned SCAN_DIV    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [5*NUM_REQ-1:0]   value_bus,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [2:0]             shown_id,
  output logic                   done,
  output logic [6:0]             seg,
  output logic [1:0]             digit_sel
);

  localparam int unsigned IdW   = $clog2(NUM_REQ);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned ScanW = $clog2(SCAN_DIV + 1);

  typedef enum logic {StIdle, StShow} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [2:0]         shown_id_q;
  logic [2:0]         last_id_q;
  logic [4:0]         shown_val_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [ScanW-1:0]   scan_cnt_q;
  logic               phase_ones_q;

  logic               found;
  logic [IdW-1:0]     cand;
  logic [2:0]         winner;
  logic [4:0]         winner_val;
  logic [4:0]         sat_val;
  logic [6:0]         tens_digit;
  logic [6:0]         ones_digit;

  // Search starts just after the last winner so a held request drops to lowest priority
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_id_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = 3'(cand);
      end
    end
  end

  assign winner_val = value_bus[5*winner +: 5];
  assign sat_val    = (winner_val > 5'd30) ? 5'd30 : winner_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      shown_id_q   <= '0;
      last_id_q    <= 3'(NUM_REQ - 1);
      shown_val_q  <= '0;
      hold_cnt_q   <= '0;
      scan_cnt_q   <= '0;
      phase_ones_q <= 1'b0;
    end else begin
      grant_q <= '0;
      case (state_q)
        StIdle: begin
          if (found) begin
            state_q      <= StShow;
            grant_q      <= NUM_REQ'(1) << winner;
            shown_id_q   <= winner;
            last_id_q    <= winner;
            shown_val_q  <= sat_val;
            hold_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            phase_ones_q <= 1'b0;
          end
        end
        StShow: begin
          if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
          if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_q   <= '0;
            phase_ones_q <= ~phase_ones_q;
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  seven_segment u_decode (
    .number     (shown_val_q),
    .tens_digit (tens_digit),
    .ones_digit (ones_digit)
  );

  assign grant     = grant_q;
  assign shown_id  = shown_id_q;
  assign busy      = (state_q == StShow);
  assign done      = busy && (hold_cnt_q == HoldW'(HOLD_CYCLES - 1));
  assign digit_sel = !busy ? 2'b00 : (phase_ones_q ? 2'b01 : 2'b10);
  assign seg       = !busy ? 7'b0 : (phase_ones_q ? ones_digit : tens_digit);

endmodule

// File: tb/tb_seven_segment_scheduler.sv
// Scoreboard bench for seven_segment_scheduler: expected grants/values are queued as requests are
// driven and checked when the DUT grants; scan, done and reset behaviour are checked per cycle.

module tb_seven_segment_scheduler;

  localparam int NR = 4;
  localparam int HC = 16;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [5*NR-1:0] value_bus;
  logic [NR-1:0] grant;
  logic          busy;
  logic [2:0]    shown_id;
  logic          done;
  logic [6:0]    seg;
  logic [1:0]    digit_sel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] grant;
    logic [2:0] id;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];

  seven_segment_scheduler #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HC),
    .SCAN_DIV    (SD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .value_bus (value_bus),
    .grant     (grant),
    .busy      (busy),
    .shown_id  (shown_id),
    .done      (done),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [4:0] sat_model(input logic [4:0] v);
    return (v > 5'd30) ? 5'd30 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_val(input int i, input logic [4:0] v);
    value_bus[5*i +: 5] = v;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (cyc < 0) begin
        tick();
        if (grant != '0) cyc = c;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    for (int c = 0; c < 40; c++) begin
      if (busy) tick();
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    value_bus = '0;
    tick();
    tick();
    n_cmp++;
    if ({grant, busy, done, shown_id, seg, digit_sel} !== {4'b0, 1'b0, 1'b0, 3'd0, 7'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_state: got grant=%b busy=%b done=%b id=%0d seg=%h sel=%b, want all zero",
               grant, busy, done, shown_id, seg, digit_sel);
    end
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (grant !== '0 || busy !== 1'b0 || seg !== 7'd0 || digit_sel !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_no_req: got grant=%b busy=%b seg=%h sel=%b, want 0/0/00/00",
               grant, busy, seg, digit_sel);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int cyc;
    logic [1:0] exp_sel;
    logic [6:0] exp_seg;
    value_bus = 20'($urandom);
    set_val(2, 5'd17);
    req = 4'b0100;
    sb.push_back('{grant: 4'b0100, id: 3'd2, val: 5'd17});
    wait_grant(cyc);
    req = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 1 || grant !== e.grant || shown_id !== e.id) begin
      n_bad++;
      $display("FAIL single_grant: got grant=%b id=%0d cyc=%0d, want grant=%b id=%0d cyc=1",
               grant, shown_id, cyc, e.grant, e.id);
    end
    for (int c = 1; c <= HC; c++) begin
      if (c > 1) tick();
      exp_sel = (((c - 1) / SD) % 2 == 0) ? 2'b10 : 2'b01;
      exp_seg = (exp_sel == 2'b10) ? seg_of(e.val / 10) : seg_of(e.val % 10);
      n_cmp++;
      if (busy !== 1'b1 || digit_sel !== exp_sel || seg !== exp_seg || done !== (c == HC) ||
          (c > 1 && grant !== '0)) begin
        n_bad++;
        $display("FAIL single_show c=%0d: got busy=%b sel=%b seg=%h done=%b grant=%b, want 1/%b/%h/%b/0",
                 c, busy, digit_sel, seg, done, grant, exp_sel, exp_seg, (c == HC));
      end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || seg !== 7'd0 || digit_sel !== 2'b00 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_end: got busy=%b seg=%h sel=%b done=%b, want 0/00/00/0",
               busy, seg, digit_sel, done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    bit ok;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_val(i, 5'(i * 7 + 2));
    req = 4'b1111;
    for (int k = 0; k < 5; k++)
      sb.push_back('{grant: 4'(1 << (k % NR)), id: 3'(k % NR), val: 5'((k % NR) * 7 + 2)});
    for (int k = 0; k < 5; k++) begin
      wait_grant(cyc);
      e = sb.pop_front();
      n_cmp++;
      if (grant !== e.grant || shown_id !== e.id || seg !== seg_of(sat_model(e.val) / 10) ||
          cyc != ((k == 0) ? 1 : HC + 1)) begin
        n_bad++;
        $display("FAIL rr_grant k=%0d: got grant=%b id=%0d seg=%h cyc=%0d, want grant=%b id=%0d seg=%h cyc=%0d",
                 k, grant, shown_id, seg, cyc, e.grant, e.id, seg_of(sat_model(e.val) / 10),
                 (k == 0) ? 1 : HC + 1);
      end
    end
    req = '0;
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rr_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int cyc;
    bit ok;
    logic [4:0] vals [4];
    vals = '{5'd31, 5'd0, 5'd30, 5'd9};
    for (int n = 0; n < 4; n++) begin
      set_val(0, vals[n]);
      req = 4'b0001;
      sb.push_back('{grant: 4'b0001, id: 3'd0, val: sat_model(vals[n])});
      wait_grant(cyc);
      req = '0;
      e = sb.pop_front();
      n_cmp++;
      if (cyc != 1 || grant !== e.grant || shown_id !== e.id || digit_sel !== 2'b10 ||
          seg !== seg_of(e.val / 10)) begin
        n_bad++;
        $display("FAIL sat_tens v=%0d: got grant=%b id=%0d sel=%b seg=%h, want grant=%b id=%0d sel=10 seg=%h",
                 vals[n], grant, shown_id, digit_sel, seg, e.grant, e.id, seg_of(e.val / 10));
      end
      for (int c = 0; c < SD; c++) tick();
      n_cmp++;
      if (digit_sel !== 2'b01 || seg !== seg_of(e.val % 10)) begin
        n_bad++;
        $display("FAIL sat_ones v=%0d: got sel=%b seg=%h, want sel=01 seg=%h",
                 vals[n], digit_sel, seg, seg_of(e.val % 10));
      end
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL sat_idle v=%0d: got busy=%b, want 0", vals[n], busy);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    exp_t e;
    int cyc;
    bit ok;
    set_val(0, 5'd12);
    req = 4'b0001;
    sb.push_back('{grant: 4'b0001, id: 3'd0, val: 5'd12});
    wait_grant(cyc);
    req = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 1 || grant !== e.grant || shown_id !== e.id) begin
      n_bad++;
      $display("FAIL rst_pre_grant: got grant=%b id=%0d cyc=%0d, want grant=%b id=%0d cyc=1",
               grant, shown_id, cyc, e.grant, e.id);
    end
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || digit_sel !== 2'b00 || done !== 1'b0 || seg !== 7'd0 || shown_id !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_mid_show: got busy=%b sel=%b done=%b seg=%h id=%0d, want 0/00/0/00/0",
               busy, digit_sel, done, seg, shown_id);
    end
    reset = 1'b0;
    set_val(0, 5'd4);
    set_val(3, 5'd25);
    req = 4'b1001;
    sb.push_back('{grant: 4'b0001, id: 3'd0, val: 5'd4});
    wait_grant(cyc);
    req = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 1 || grant !== e.grant || shown_id !== e.id || seg !== seg_of(e.val / 10)) begin
      n_bad++;
      $display("FAIL rst_post_grant: got grant=%b id=%0d seg=%h cyc=%0d, want grant=%b id=%0d seg=%h cyc=1",
               grant, shown_id, seg, cyc, e.grant, e.id, seg_of(e.val / 10));
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rst_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_req_drop();
    exp_t e;
    int cyc;
    int done_cnt;
    logic [1:0] exp_sel;
    logic [6:0] exp_seg;
    set_val(1, 5'd22);
    req = 4'b0010;
    sb.push_back('{grant: 4'b0010, id: 3'd1, val: 5'd22});
    wait_grant(cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 1 || grant !== e.grant || shown_id !== e.id) begin
      n_bad++;
      $display("FAIL drop_grant: got grant=%b id=%0d cyc=%0d, want grant=%b id=%0d cyc=1",
               grant, shown_id, cyc, e.grant, e.id);
    end
    done_cnt = done ? 1 : 0;
    tick();
    if (done) done_cnt++;
    tick();
    if (done) done_cnt++;
    req = '0;
    set_val(1, 5'd5);
    for (int c = 4; c <= HC; c++) begin
      tick();
      if (done) done_cnt++;
      exp_sel = (((c - 1) / SD) % 2 == 0) ? 2'b10 : 2'b01;
      exp_seg = (exp_sel == 2'b10) ? seg_of(e.val / 10) : seg_of(e.val % 10);
      n_cmp++;
      if (busy !== 1'b1 || digit_sel !== exp_sel || seg !== exp_seg || shown_id !== e.id) begin
        n_bad++;
        $display("FAIL drop_show c=%0d: got busy=%b sel=%b seg=%h id=%0d, want 1/%b/%h/%0d",
                 c, busy, digit_sel, seg, shown_id, exp_sel, exp_seg, e.id);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL drop_done: got done=%b count=%0d on cycle %0d, want done=1 count=1", done, done_cnt, HC);
    end
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_bad++;
      $display("FAIL drop_idle: got busy=%b grant=%b, want 0/0000", busy, grant);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    int cyc;
    bit ok;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_val(0, 5'd8);
    req = 4'b0001;
    sb.push_back('{grant: 4'b0001, id: 3'd0, val: 5'd8});
    wait_grant(cyc);
    req = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 1 || grant !== e.grant || shown_id !== e.id) begin
      n_bad++;
      $display("FAIL prio_setup: got grant=%b id=%0d cyc=%0d, want grant=%b id=%0d cyc=1",
               grant, shown_id, cyc, e.grant, e.id);
    end
    wait_idle(ok);
    set_val(0, 5'd11);
    set_val(1, 5'd29);
    req = 4'b0011;
    sb.push_back('{grant: 4'b0010, id: 3'd1, val: 5'd29});
    sb.push_back('{grant: 4'b0001, id: 3'd0, val: 5'd11});
    for (int k = 0; k < 2; k++) begin
      wait_grant(cyc);
      e = sb.pop_front();
      n_cmp++;
      if (grant !== e.grant || shown_id !== e.id || seg !== seg_of(e.val / 10) ||
          cyc != ((k == 0) ? 1 : HC + 1)) begin
        n_bad++;
        $display("FAIL prio_grant k=%0d: got grant=%b id=%0d seg=%h cyc=%0d, want grant=%b id=%0d seg=%h cyc=%0d",
                 k, grant, shown_id, seg, cyc, e.grant, e.id, seg_of(e.val / 10), (k == 0) ? 1 : HC + 1);
      end
    end
    req = '0;
    wait_idle(ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_bad++;
      $display("FAIL prio_end: got busy=%b pending=%0d, want 0/0", busy, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    value_bus = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_reset_mid_show();
    test_req_drop();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
